// File: rtl/instr_fetch_queue_pkg.sv
// Shared sizing defaults and FSM encodings for the instruction fetch queue.
package instr_fetch_queue_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int PC_W   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: registered level, head word visible one cycle after its push (no bypass).
// Backpressure: push_rdy drops while full; a same-cycle pop does not reopen it until the next cycle.
module instr_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int FW = WIDTH,
  parameter int FD = DEPTH,
  parameter int FA = ADDR_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push_vld,
  input  logic [FW-1:0] push_dat,
  output logic          push_rdy,
  input  logic          pop,
  output logic [FW-1:0] head_dat,
  output logic [FA:0]   level
);

  logic [FW-1:0] mem [FD];
  logic [FA-1:0] wr_ptr;
  logic [FA-1:0] rd_ptr;
  logic          push;

  assign push_rdy = (level != (FA+1)'(FD));
  assign push     = push_vld & push_rdy;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FA'(1);
      if (pop)  rd_ptr <= rd_ptr + FA'(1);
      case ({push, pop})
        2'b10:   level <= level + (FA+1)'(1);
        2'b01:   level <= level - (FA+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Feeds queued instructions to the core one at a time, holding iin until done; counts retirements.
// Latency 2 cycles push-to-iin on an idle queue; back-to-back issue with no bubble while words remain.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_valid,
  input  logic [WIDTH-1:0]  load_data,
  output logic              load_ready,
  input  logic              done,
  output logic [WIDTH-1:0]  iin,
  output logic              iin_valid,
  output logic [PC_W-1:0]   pc,
  output logic [ADDR_W:0]   level,
  output logic              spurious_done
);

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  iin_nxt;
  logic              iin_valid_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              spurious_nxt;
  logic              pop;
  logic [WIDTH-1:0]  head_dat;
  logic              have_word;

  instr_fifo u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push_vld (load_valid),
    .push_dat (load_data),
    .push_rdy (load_ready),
    .pop      (pop),
    .head_dat (head_dat),
    .level    (level)
  );

  assign have_word = (level != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      iin           <= '0;
      iin_valid     <= 1'b0;
      pc            <= '0;
      spurious_done <= 1'b0;
    end else begin
      state         <= state_nxt;
      iin           <= iin_nxt;
      iin_valid     <= iin_valid_nxt;
      pc            <= pc_nxt;
      spurious_done <= spurious_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    iin_nxt       = iin;
    iin_valid_nxt = iin_valid;
    pc_nxt        = pc;
    spurious_nxt  = spurious_done;
    pop           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (done) spurious_nxt = 1'b1;
        if (have_word) begin
          pop           = 1'b1;
          iin_nxt       = head_dat;
          iin_valid_nxt = 1'b1;
          state_nxt     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (done) begin
          pc_nxt = pc + PC_W'(1);
          if (have_word) begin
            pop     = 1'b1;
            iin_nxt = head_dat;
          end else begin
            iin_nxt       = '0;
            iin_valid_nxt = 1'b0;
            state_nxt     = ST_IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with hand-computed expectations.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        done;
  logic [15:0] iin;
  logic        iin_valid;
  logic [7:0]  pc;
  logic [3:0]  level;
  logic        spurious_done;

  int errors = 0;
  int checks = 0;

  instr_fetch_queue dut (
    .clk           (clk),
    .resetn        (resetn),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_ready    (load_ready),
    .done          (done),
    .iin           (iin),
    .iin_valid     (iin_valid),
    .pc            (pc),
    .level         (level),
    .spurious_done (spurious_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_iin"},       32'(iin), 32'h0);
    chk({tag, "_iin_valid"}, 32'(iin_valid), 32'h0);
    chk({tag, "_pc"},        32'(pc), 32'h0);
    chk({tag, "_level"},     32'(level), 32'h0);
    chk({tag, "_ready"},     32'(load_ready), 32'h1);
    chk({tag, "_spurious"},  32'(spurious_done), 32'h0);
  endtask

  logic [15:0] exp_q[$];
  int pushed;
  int retired;
  int cyc;
  logic [15:0] head;

  initial begin
    resetn = 1'b0; load_valid = 1'b0; load_data = '0; done = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    resetn = 1'b1;
    tick();

    // 1: single word, two-cycle latency
    load_valid = 1'b1; load_data = 16'h1234;
    tick();
    load_valid = 1'b0;
    chk("t1_level_after_push", 32'(level), 32'h1);
    chk("t1_no_bypass", 32'(iin_valid), 32'h0);
    tick();
    chk("t1_iin", 32'(iin), 32'h1234);
    chk("t1_iin_valid", 32'(iin_valid), 32'h1);
    chk("t1_level", 32'(level), 32'h0);
    chk("t1_pc", 32'(pc), 32'h0);
    tick(); tick();
    chk("t1_hold", 32'(iin), 32'h1234);
    done = 1'b1; tick(); done = 1'b0;
    chk("t1_pc_after_done", 32'(pc), 32'h1);
    chk("t1_idle_valid", 32'(iin_valid), 32'h0);
    chk("t1_idle_iin", 32'(iin), 32'h0);

    // 2: three words, back-to-back retire
    load_valid = 1'b1; load_data = 16'hA001; tick();
    load_data = 16'hA002; tick();
    load_data = 16'hA003; tick();
    load_valid = 1'b0;
    chk("t2_iin0", 32'(iin), 32'hA001);
    chk("t2_level0", 32'(level), 32'h2);
    done = 1'b1; tick();
    chk("t2_iin1", 32'(iin), 32'hA002);
    chk("t2_valid1", 32'(iin_valid), 32'h1);
    tick();
    chk("t2_iin2", 32'(iin), 32'hA003);
    chk("t2_valid2", 32'(iin_valid), 32'h1);
    chk("t2_level2", 32'(level), 32'h0);
    tick(); done = 1'b0;
    chk("t2_end_valid", 32'(iin_valid), 32'h0);
    chk("t2_end_iin", 32'(iin), 32'h0);
    chk("t2_pc", 32'(pc), 32'h4);

    // 3: fill to full, refuse 10th word, drain one by one
    load_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      load_data = 16'hB000 + 16'(i);
      chk($sformatf("t3_ready_%0d", i), 32'(load_ready), 32'h1);
      tick();
    end
    chk("t3_full_level", 32'(level), 32'h8);
    chk("t3_full_ready", 32'(load_ready), 32'h0);
    chk("t3_first_iin", 32'(iin), 32'hB000);
    load_data = 16'hB009; tick();
    load_valid = 1'b0;
    chk("t3_refused_level", 32'(level), 32'h8);
    done = 1'b1; tick(); done = 1'b0;
    chk("t3_pop_level", 32'(level), 32'h7);
    chk("t3_pop_ready", 32'(load_ready), 32'h1);
    chk("t3_pop_iin", 32'(iin), 32'hB001);
    for (int i = 2; i < 9; i++) begin
      done = 1'b1; tick(); done = 1'b0;
      chk($sformatf("t3_drain_%0d", i), 32'(iin), 32'(16'hB000 + 16'(i)));
    end
    done = 1'b1; tick(); done = 1'b0;
    chk("t3_empty_valid", 32'(iin_valid), 32'h0);
    chk("t3_pc", 32'(pc), 32'd13);

    // 4: 20 words streamed across pointer wrap, order scoreboarded
    pushed = 0; retired = 0; cyc = 0;
    while (retired < 20 && cyc < 400) begin
      load_valid = (pushed < 20) && (cyc % 4 != 1);
      load_data  = 16'hC100 + 16'(pushed);
      done       = iin_valid && (cyc % 3 != 0);
      if (load_valid && load_ready) begin
        exp_q.push_back(load_data);
        pushed++;
      end
      if (done && iin_valid) begin
        if (exp_q.size() == 0) begin
          chk("t4_unexpected_retire", 32'(iin), 32'hFFFF_FFFF);
        end else begin
          head = exp_q.pop_front();
          chk($sformatf("t4_order_%0d", retired), 32'(iin), 32'(head));
        end
        retired++;
      end
      tick();
      cyc++;
    end
    load_valid = 1'b0; done = 1'b0;
    chk("t4_all_retired", 32'(retired), 32'd20);
    chk("t4_pc", 32'(pc), 32'd33);
    chk("t4_no_spurious", 32'(spurious_done), 32'h0);

    // 5: done while idle
    tick();
    chk("t5_idle", 32'(iin_valid), 32'h0);
    done = 1'b1; tick(); done = 1'b0;
    chk("t5_spurious", 32'(spurious_done), 32'h1);
    chk("t5_pc", 32'(pc), 32'd33);
    chk("t5_valid", 32'(iin_valid), 32'h0);
    tick(); tick();
    chk("t5_sticky", 32'(spurious_done), 32'h1);

    // 6: async reset mid-stream
    load_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_data = 16'hD000 + 16'(i);
      tick();
    end
    load_valid = 1'b0;
    chk("t6_level", 32'(level), 32'h5);
    chk("t6_valid", 32'(iin_valid), 32'h1);
    chk("t6_iin", 32'(iin), 32'hD000);
    #1 resetn = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    tick();
    #1 resetn = 1'b1;
    tick();
    load_valid = 1'b1; load_data = 16'hC0DE; tick();
    load_valid = 1'b0; tick();
    chk("t6_new_iin", 32'(iin), 32'hC0DE);
    chk("t6_new_valid", 32'(iin_valid), 32'h1);
    chk("t6_new_pc", 32'(pc), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
